multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I datapath (subset: R-type, lw, sw, beq).
- Sequences fetch, decode, execute, memory and writeback.
- Drives the 2-bit alu_op consumed by the existing ALU-control decoder, plus all datapath mux selects and write enables.
- Holds on a single shared instruction/data memory via a ready handshake, counts retired instructions, and halts on illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  7  instr[6:0] from the instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero flag set (datapath ANDs it with zero).
- pc_source  output  1  0 = ALU result, 1 = ALUOut register.
- iord  output  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  load instruction register.
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate (branch offset).
- alu_op  output  2  00 = add, 01 = subtract (beq), 10 = decode func3/func7.
- halted  output  1  illegal opcode seen; sticky until reset.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
Reset
- rst=1 at a rising edge puts state in FETCH and clears instret.
- While rst=1, every output is forced to 0, including halted and instret.
- Reset mid-instruction abandons it with no further writes.

Opcodes
- R = 0110011, LW = 0000011, SW = 0100011, BEQ = 1100011.
- Anything else is illegal.

States
- Outputs not listed for a state are 0. Outputs are Moore decode of state, except the ready-qualified ones in FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0. ir_write and pc_write are 1 only in the cycle mem_ready=1. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state: R→EXECUTE; LW or SW→MEM_ADDR; BEQ→BRANCH; illegal→HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW→MEM_READ, SW→MEM_WRITE. opcode is stable because IR is held.
- MEM_READ: mem_read=1, iord=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Next: FETCH.
- MEM_WRITE: mem_write=1, iord=1. Wait for mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Next: FETCH.
- HALT: halted=1, all other outputs 0. Ignores opcode and mem_ready; leaves only via rst.

Memory request rules
- mem_read/mem_write stay asserted for the full wait.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.

instret
- Increments by 1 on the edge leaving MEM_WB, ALU_WB, BRANCH, or MEM_WRITE with mem_ready=1.
- Wraps modulo 2^CNT_W.
- Never increments for an illegal instruction.

Latency (cycles, mem_ready tied 1)
- R = 4, LW = 5, SW = 4, BEQ = 3.
- Each cycle mem_ready=0 in a wait state adds 1.

Invariant
- mem_read and mem_write are never 1 together.

Decomposition:
- Shared package holds:
  - state enum (FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, HALT);
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ;
  - alu_op codes ALUOP_ADD/ALUOP_SUB/ALUOP_FUNC;
  - alu_src_b codes SRCB_REG/SRCB_FOUR/SRCB_IMM/SRCB_BR.
- The ALU-control decoder is reused unchanged, driven by alu_op.
- No sub-module: state register, next-state logic, output decode and counter form one module.

Test Plan:
- Reset then R-type (opcode 0110011), mem_ready=1 → states FETCH, DECODE, EXECUTE, ALU_WB, FETCH. EXECUTE shows alu_op=10; ALU_WB shows reg_write=1; instret=1 after 4 cycles.
- LW with mem_ready low 2 cycles in MEM_READ → mem_read=1 and iord=1 held 3 cycles. MEM_WB shows reg_write=1, mem_to_reg=1; total 7 cycles; instret +1.
- SW then BEQ back-to-back → SW: mem_write=1 one cycle, no reg_write. BEQ: pc_write_cond=1, alu_op=01, pc_source=1 in BRANCH. instret=2 after 7 cycles.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH → ir_write and pc_write stay 0 until the ready cycle, where both pulse for exactly 1 cycle.
- Illegal opcode 1111111 → HALT after DECODE; halted=1 and all enables 0 for 20 cycles regardless of mem_ready; instret unchanged. rst=1 → FETCH, halted=0, instret=0.
- rst asserted in MEM_WRITE while mem_ready=0 → next cycle all outputs 0 and instret=0. After release, FETCH with mem_read=1; no mem_write pulse ever seen.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multi-cycle RV32I main control FSM:
//   - state_t     : control FSM states
//   - OP_*        : supported instr[6:0] opcodes (R-type, lw, sw, beq)
//   - ALUOP_*     : 2-bit alu_op codes consumed by the ALU-control decoder
//   - SRCB_*      : alu_src_b mux select codes
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      ALU_WB    = 4'd7,
      BRANCH    = 4'd8,
      HALT      = 4'd9
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Main control FSM for the multi-cycle RV32I datapath (R-type, lw, sw, beq).
// Sequences fetch / decode / execute / memory / writeback over one shared
// instruction/data memory with a ready handshake, counts retired
// instructions and parks in HALT on an illegal opcode.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode[6:0]       instr[6:0] from the instruction register
//   mem_ready         memory finishes the current access this cycle
//   pc_write          unconditional PC load
//   pc_write_cond     PC load qualified by ALU zero in the datapath
//   pc_source         0 = ALU result, 1 = ALUOut
//   iord              memory address: 0 = PC, 1 = ALUOut
//   mem_read          memory read request
//   mem_write         memory write request
//   ir_write          load instruction register
//   mem_to_reg        register write data: 0 = ALUOut, 1 = MDR
//   reg_write         register file write enable
//   alu_src_a         0 = PC, 1 = register A
//   alu_src_b[1:0]    00 = B, 01 = 4, 10 = imm, 11 = branch offset
//   alu_op[1:0]       00 = add, 01 = subtract, 10 = decode func fields
//   halted            sticky illegal-opcode flag
//   instret[CNT_W-1:0] retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_source,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  instret_q;
   logic              retire;

   // An instruction retires on the edge that leaves its final state; a store
   // only retires once the memory has accepted the write.
   assign retire = (state == MEM_WB) || (state == ALU_WB) || (state == BRANCH) ||
                   ((state == MEM_WRITE) && mem_ready);

   // State register and retired-instruction counter. Reset abandons any
   // in-flight instruction and restarts at FETCH with the count cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         instret_q <= '0;
      end else begin
         state <= next_state;
         if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

   // The count is hidden while reset is held so every output reads zero.
   assign instret = rst ? '0 : instret_q;

   // Next-state and output decode. Outputs are a Moore decode of the state,
   // except ir_write/pc_write in FETCH which only fire on the ready cycle so
   // the IR and PC update exactly once per fetch. Reset overrides everything
   // to zero so nothing in the datapath is written while it is asserted.
   always_comb begin
      next_state    = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALUOP_ADD;
      halted        = 1'b0;

      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               next_state = DECODE;
            end
         end
         DECODE: begin
            alu_src_b = SRCB_BR;
            case (opcode)
               OP_R:         next_state = EXECUTE;
               OP_LW, OP_SW: next_state = MEM_ADDR;
               OP_BEQ:       next_state = BRANCH;
               default:      next_state = HALT;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               next_state = MEM_WB;
            end
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            next_state = FETCH;
         end
         MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               next_state = FETCH;
            end
         end
         EXECUTE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_REG;
            alu_op     = ALUOP_FUNC;
            next_state = ALU_WB;
         end
         ALU_WB: begin
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_REG;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
            next_state    = FETCH;
         end
         HALT: begin
            halted     = 1'b1;
            next_state = HALT;
         end
         default: begin
            next_state = FETCH;
         end
      endcase

      if (rst) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         pc_source     = 1'b0;
         iord          = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mem_to_reg    = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = SRCB_REG;
         alu_op        = ALUOP_ADD;
         halted        = 1'b0;
      end
   end

endmodule
